bit_hunt_game: RTL and testbench

- Parametrised "hunt the bit" reaction game for the board's LED/button bank.
- A lit pattern rotates across NumLeds LEDs; the player presses buttons under lit LEDs to clear them.
- Adds the following to the game:
  - multiple lives with a miss-flash
  - level progression with a period floor
  - selectable rotation direction
  - a saturating BCD score
  - a restart input
- Sits between the button debouncers and the LED/seven-segment drivers.

---
 rtl/bit_hunt_game.sv | 233 +++++++++++++++++++++++
 tb/tb_bit_hunt_game.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_hunt_game.sv
// Hunt-the-bit reaction game: a lit pattern rotates across the LED bank and
// the player clears lit bits by pressing the buttons beneath them. Tracks
// lives, levels (with a shrinking rotation period), and a saturating BCD score.

`ifndef CLOCK_FREQ_HZ
`define CLOCK_FREQ_HZ 50_000_000
`endif

module bit_hunt_game #(
   parameter int unsigned        NumLeds      = 16,
   parameter int unsigned        MaxPeriod    = `CLOCK_FREQ_HZ / 4,
   parameter int unsigned        MinPeriod    = `CLOCK_FREQ_HZ / 64,
   parameter int unsigned        NumLives     = 3,
   parameter int unsigned        FlashCycles  = `CLOCK_FREQ_HZ / 8,
   parameter int unsigned        ScoreDigits  = 4,
   parameter logic [NumLeds-1:0] StartPattern = NumLeds'(16'h0F00)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NumLeds-1:0]       button,
   input  logic                     dir,
   input  logic                     start,
   output logic [NumLeds-1:0]       led,
   output logic [4*ScoreDigits-1:0] score_bcd,
   output logic [3:0]               lives,
   output logic [3:0]               level,
   output logic                     game_over
);

   localparam int unsigned CntMax = (MaxPeriod > FlashCycles) ? MaxPeriod : FlashCycles;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned ScoreW = 4 * ScoreDigits;

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t              MaxPeriodC = cnt_t'(MaxPeriod);
   localparam cnt_t              MinPeriodC = cnt_t'(MinPeriod);
   localparam cnt_t              FlashLastC = cnt_t'(FlashCycles - 1);
   localparam logic [3:0]        NumLivesC  = 4'(NumLives);
   localparam logic [ScoreW-1:0] ScoreMax   = {ScoreDigits{4'h9}};

   typedef enum logic [2:0] {
      StStart,
      StWait,
      StRotate,
      StHit,
      StLevelUp,
      StMiss,
      StGameOver
   } state_e;

   state_e              state_q, state_d;
   cnt_t                cnt_q, cnt_d;
   cnt_t                period_q, period_d;
   logic [NumLeds-1:0]  pattern_q, pattern_d;
   logic [NumLeds-1:0]  button_q;
   logic [NumLeds-1:0]  press_q, press_d;
   logic [ScoreW-1:0]   score_q, score_d;
   logic [3:0]          lives_q, lives_d;
   logic [3:0]          level_q, level_d;
   logic                blink_q, blink_d;

   logic [NumLeds-1:0]  press;
   logic [NumLeds-1:0]  pattern_cleared;
   logic                miss, hit, timeout, flash_done;
   cnt_t                period_half, period_next;
   logic [ScoreW-1:0]   score_inc;
   logic [ScoreDigits:0] carry;

   assign press           = button & ~button_q;
   assign miss            = |(press & ~pattern_q);
   assign hit             = |(press & pattern_q);
   assign timeout         = (cnt_q == period_q - cnt_t'(1));
   assign flash_done      = (cnt_q == FlashLastC);
   assign pattern_cleared = pattern_q & ~press_q;
   assign period_half     = period_q >> 1;
   assign period_next     = (period_half < MinPeriodC) ? MinPeriodC : period_half;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StStart;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection; in WAIT a miss beats a hit, which beats the timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStart:   state_d = StWait;
         StWait: begin
            if (miss) begin
               state_d = StMiss;
            end else if (hit) begin
               state_d = StHit;
            end else if (timeout) begin
               state_d = StRotate;
            end
         end
         StRotate:  state_d = StWait;
         StHit:     state_d = (pattern_cleared == '0) ? StLevelUp : StWait;
         StLevelUp: state_d = StWait;
         // lives already decremented on entry, so zero here means the last life went
         StMiss: begin
            if (lives_q == 4'd0) begin
               state_d = StGameOver;
            end else if (flash_done) begin
               state_d = StWait;
            end
         end
         StGameOver: begin
            if (start) begin
               state_d = StStart;
            end
         end
         default:   state_d = StStart;
      endcase
   end

   // BCD increment with decimal carry ripple
   always_comb begin
      score_inc = score_q;
      carry     = '0;
      carry[0]  = 1'b1;
      for (int d = 0; d < ScoreDigits; d++) begin
         if (carry[d]) begin
            if (score_q[4*d +: 4] == 4'd9) begin
               score_inc[4*d +: 4] = 4'd0;
               carry[d+1]          = 1'b1;
            end else begin
               score_inc[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
            end
         end
      end
   end

   // Datapath next-state: counter, pattern, score, lives, level, period, blink
   always_comb begin
      pattern_d = pattern_q;
      period_d  = period_q;
      score_d   = score_q;
      lives_d   = lives_q;
      level_d   = level_q;
      press_d   = (state_q == StWait) ? press : press_q;

      cnt_d = cnt_q + cnt_t'(1);
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == StGameOver) && flash_done) begin
         cnt_d = '0;
      end

      blink_d = (state_q == StGameOver) ? (blink_q ^ flash_done) : 1'b0;

      unique case (state_q)
         StStart: pattern_d = StartPattern;
         StWait: begin
            if (miss) begin
               lives_d = lives_q - 4'd1;
            end
         end
         StRotate: begin
            if (dir) begin
               pattern_d = {pattern_q[NumLeds-2:0], pattern_q[NumLeds-1]};
            end else begin
               pattern_d = {pattern_q[0], pattern_q[NumLeds-1:1]};
            end
         end
         StHit: begin
            pattern_d = pattern_cleared;
            score_d   = (score_q == ScoreMax) ? score_q : score_inc;
         end
         StLevelUp: begin
            period_d  = period_next;
            level_d   = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            pattern_d = StartPattern;
         end
         StGameOver: begin
            if (start) begin
               score_d  = '0;
               lives_d  = NumLivesC;
               level_d  = 4'd0;
               period_d = MaxPeriodC;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; button history updates every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         period_q  <= MaxPeriodC;
         pattern_q <= StartPattern;
         button_q  <= '0;
         press_q   <= '0;
         score_q   <= '0;
         lives_q   <= NumLivesC;
         level_q   <= 4'd0;
         blink_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         pattern_q <= pattern_d;
         button_q  <= button;
         press_q   <= press_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         level_q   <= level_d;
         blink_q   <= blink_d;
      end
   end

   // Output decode; blink_q low means the all-ones phase of the game-over blink
   always_comb begin
      led = pattern_q;
      unique case (state_q)
         StStart:    led = StartPattern;
         StMiss:     led = '1;
         StGameOver: led = blink_q ? '0 : '1;
         default:    led = pattern_q;
      endcase
      game_over = (state_q == StGameOver);
   end

   assign score_bcd = score_q;
   assign lives     = lives_q;
   assign level     = level_q;

endmodule

// File: tb/tb_bit_hunt_game.sv
// Bench for bit_hunt_game: a behavioural game model tracked alongside the DUT,
// checked every cycle, plus directed scenarios with hand-computed values.

module tb_bit_hunt_game;

   localparam logic [7:0] Start8 = 8'h0F;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] button;
   logic       dir;
   logic       start;
   logic [7:0] led;
   logic [7:0] score_bcd;
   logic [3:0] lives;
   logic [3:0] level;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bit_hunt_game #(
      .NumLeds      (8),
      .MaxPeriod    (8),
      .MinPeriod    (2),
      .NumLives     (2),
      .FlashCycles  (4),
      .ScoreDigits  (2),
      .StartPattern (Start8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .dir       (dir),
      .start     (start),
      .led       (led),
      .score_bcd (score_bcd),
      .lives     (lives),
      .level     (level),
      .game_over (game_over)
   );

   // ---------------- behavioural game model ----------------
   typedef enum int {MStart, MWait, MRotate, MHit, MLevelUp, MMiss, MOver} mphase_t;

   mphase_t    m_phase   = MStart;
   int         m_elapsed = 0;
   int         m_period  = 8;
   bit [7:0]   m_lit     = 8'h0F;
   bit [7:0]   m_prev    = 8'h00;
   bit [7:0]   m_taken   = 8'h00;
   int         m_score   = 0;
   int         m_lives   = 2;
   int         m_level   = 0;
   bit         m_dark    = 1'b0;

   function automatic void go(mphase_t p);
      m_phase   = p;
      m_elapsed = 0;
   endfunction

   function automatic void model_step();
      bit [7:0] pr;
      if (rst) begin
         m_phase = MStart; m_elapsed = 0; m_period = 8; m_lit = Start8;
         m_prev = 8'h00; m_taken = 8'h00; m_score = 0; m_lives = 2; m_level = 0;
         m_dark = 1'b0;
         return;
      end
      pr     = button & ~m_prev;
      m_prev = button;
      case (m_phase)
         MStart: begin m_lit = Start8; go(MWait); end
         MWait: begin
            if ((pr & ~m_lit) != 0) begin
               m_lives = m_lives - 1;
               go(MMiss);
            end else if ((pr & m_lit) != 0) begin
               m_taken = pr;
               go(MHit);
            end else if (m_elapsed == m_period - 1) begin
               go(MRotate);
            end else begin
               m_elapsed++;
            end
         end
         MRotate: begin
            m_lit = dir ? ((m_lit << 1) | (m_lit >> 7)) : ((m_lit >> 1) | (m_lit << 7));
            go(MWait);
         end
         MHit: begin
            m_lit = m_lit & ~m_taken;
            if (m_score < 99) m_score++;
            go((m_lit == 0) ? MLevelUp : MWait);
         end
         MLevelUp: begin
            m_period = (m_period / 2 < 2) ? 2 : m_period / 2;
            if (m_level < 15) m_level++;
            m_lit = Start8;
            go(MWait);
         end
         MMiss: begin
            if (m_lives == 0) begin
               m_dark = 1'b0;
               go(MOver);
            end else if (m_elapsed == 3) begin
               go(MWait);
            end else begin
               m_elapsed++;
            end
         end
         MOver: begin
            if (start) begin
               m_score = 0; m_lives = 2; m_level = 0; m_period = 8;
               go(MStart);
            end else if (m_elapsed == 3) begin
               m_elapsed = 0;
               m_dark    = ~m_dark;
            end else begin
               m_elapsed++;
            end
         end
         default: go(MStart);
      endcase
   endfunction

   function automatic logic [7:0] exp_led();
      case (m_phase)
         MStart:  return Start8;
         MMiss:   return 8'hFF;
         MOver:   return m_dark ? 8'h00 : 8'hFF;
         default: return m_lit;
      endcase
   endfunction

   function automatic logic [7:0] exp_bcd();
      logic [7:0] r;
      r[7:4] = 4'((m_score / 10) % 10);
      r[3:0] = 4'(m_score % 10);
      return r;
   endfunction

   always @(posedge clk) model_step();

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_led", 32'(led), 32'(exp_led()));
      check("model_score", 32'(score_bcd), 32'(exp_bcd()));
      check("model_lives", 32'(lives), 32'(m_lives));
      check("model_level", 32'(level), 32'(m_level));
      check("model_game_over", 32'(game_over), 32'(m_phase == MOver));
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press(input logic [7:0] mask);
      button = mask;
      @(negedge clk);
      button = 8'h00;
      @(negedge clk);
   endtask

   task automatic wait_change(output int k, output logic [7:0] v);
      logic [7:0] first;
      first = led;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (led == first && k < 100);
      v = led;
      if (k >= 100) check("change_timeout", 32'(k), 32'd0);
   endtask

   task automatic run_len(input logic [7:0] val, output int k);
      k = 0;
      while (led == val && k < 50) begin
         @(negedge clk);
         k++;
      end
   endtask

   function automatic logic [7:0] lowest(input logic [7:0] m);
      for (int i = 0; i < 8; i++) if (m[i]) return 8'(1 << i);
      return 8'h00;
   endfunction

   int         k;
   logic [7:0] v;
   int         guard;

   initial begin
      rst = 1'b1; button = 8'h00; dir = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_led", 32'(led), 32'h0F);
      check("reset_lives", 32'(lives), 32'd2);
      check("reset_score", 32'(score_bcd), 32'd0);
      check("reset_game_over", 32'(game_over), 32'd0);

      // Rotation right, then left
      wait_change(k, v);
      check("rot_r1_val", 32'(v), 32'h87);
      check("rot_r1_gap", 32'(k), 32'd10);
      wait_change(k, v);
      check("rot_r2_val", 32'(v), 32'hC3);
      check("rot_r2_gap", 32'(k), 32'd9);
      dir = 1'b1;
      do_reset();
      wait_change(k, v);
      check("rot_l1_val", 32'(v), 32'h1E);
      wait_change(k, v);
      check("rot_l2_val", 32'(v), 32'h3C);
      check("rot_l2_gap", 32'(k), 32'd9);
      dir = 1'b0;

      // Hit, then clear the rest for a level-up
      do_reset();
      @(negedge clk);
      press(8'h01);
      check("hit_led", 32'(led), 32'h0E);
      check("hit_score", 32'(score_bcd), 32'h01);
      press(8'h0E);
      @(negedge clk);
      check("lvl_led", 32'(led), 32'h0F);
      check("lvl_score", 32'(score_bcd), 32'h02);
      check("lvl_level", 32'(level), 32'd1);
      wait_change(k, v);
      check("lvl_gap", 32'(k), 32'd5);
      check("lvl_rot", 32'(v), 32'h87);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("start_in_wait_level", 32'(level), 32'd1);
      check("start_in_wait_over", 32'(game_over), 32'd0);

      // Misses down to game over, then restart
      do_reset();
      @(negedge clk);
      press(8'h01);
      button = 8'h10;
      @(negedge clk);
      button = 8'h00;
      check("miss1_lives", 32'(lives), 32'd1);
      check("miss1_led", 32'(led), 32'hFF);
      run_len(8'hFF, k);
      check("miss1_flash_len", 32'(k), 32'd4);
      check("miss1_back", 32'(led), 32'h0E);
      button = 8'h10;
      @(negedge clk);
      button = 8'h00;
      @(negedge clk);
      check("over_flag", 32'(game_over), 32'd1);
      check("over_lives", 32'(lives), 32'd0);
      run_len(8'hFF, k);
      check("over_on_len", 32'(k), 32'd4);
      run_len(8'h00, k);
      check("over_off_len", 32'(k), 32'd4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_led", 32'(led), 32'h0F);
      check("restart_score", 32'(score_bcd), 32'h00);
      check("restart_lives", 32'(lives), 32'd2);

      // Mixed press: one lit, one unlit
      do_reset();
      @(negedge clk);
      press(8'h01);
      press(8'h82);
      check("mixed_score", 32'(score_bcd), 32'h01);
      check("mixed_lives", 32'(lives), 32'd1);

      // Correct press on the timeout cycle wins over rotation
      do_reset();
      repeat (8) @(negedge clk);
      button = 8'h01;
      @(negedge clk);
      button = 8'h00;
      @(negedge clk);
      check("timeout_hit_led", 32'(led), 32'h0E);
      wait_change(k, v);
      check("timeout_restart_gap", 32'(k), 32'd9);
      check("timeout_restart_val", 32'(v), 32'h07);

      // Drive the score to saturation
      do_reset();
      guard = 0;
      while (m_score < 99 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (m_phase == MWait && m_lit != 0) press(lowest(m_lit));
      end
      check("sat_score", 32'(score_bcd), 32'h99);
      check("sat_level", 32'(level), 32'd15);
      guard = 0;
      while (m_phase != MWait && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      press(lowest(m_lit));
      @(negedge clk);
      check("sat_hold", 32'(score_bcd), 32'h99);

      // Reset in the middle of a miss flash
      guard = 0;
      while (m_phase != MWait && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      button = lowest(~m_lit);
      @(negedge clk);
      button = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_flash_led", 32'(led), 32'h0F);
      check("rst_flash_lives", 32'(lives), 32'd2);
      check("rst_flash_score", 32'(score_bcd), 32'h00);

      // Random play
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0 && m_phase == MWait && m_lit != 0) begin
            button = lowest(m_lit);
         end else if ($urandom_range(0, 11) == 0) begin
            button = 8'($urandom) & 8'($urandom) & 8'($urandom);
         end else begin
            button = 8'h00;
         end
         dir   = ($urandom_range(0, 15) == 0) ? ~dir : dir;
         start = ($urandom_range(0, 19) == 0);
         rst   = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk);
      rst = 1'b0; button = 8'h00; start = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
